// File: rtl/ddc112_pkg.sv
// Shared types and constants for the DDC112 chip-side readout emulator.
package ddc112_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    VALID   = 2'd2,
    SHIFT   = 2'd3
  } emu_state_e;

  localparam int unsigned FRAME_BITS     = 40;
  localparam int unsigned DATA_W_DEFAULT = 20;

endpackage

// File: rtl/ddc112_sync_edge.sv
// Two-flop synchronizer with registered history for single-cycle rise/fall pulses.
module ddc112_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ddc112_chip_emu.sv
// DDC112 serial-readout chip emulator (CONV/DCLK/DXMIT_BAR in, DVALID_BAR/DOUT out).
// Build option: DDC112_EMU_RAMP_EN replaces data_a/data_b with an internal ramp pattern.
module ddc112_chip_emu
  import ddc112_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 42200,
  parameter int unsigned DATA_W      = DATA_W_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              CONV,
  input  logic              DCLK,
  input  logic              DXMIT_BAR,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              DVALID_BAR,
  output logic              DOUT,
  output logic              overrun,
  output logic [1:0]        emu_state
);

  localparam int unsigned FW    = 2 * DATA_W;
  localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int unsigned BIT_W = $clog2(FW + 1);

  logic conv_rise, conv_fall, dclk_rise, dclk_fall, xmit_rise, xmit_fall;
  logic conv_edge;

  ddc112_sync_edge #(.RESET_VAL(1'b0)) u_sync_conv (
    .clk_i(sys_clk), .rst_ni(reset_n), .async_i(CONV),
    .rise_o(conv_rise), .fall_o(conv_fall)
  );

  ddc112_sync_edge #(.RESET_VAL(1'b0)) u_sync_dclk (
    .clk_i(sys_clk), .rst_ni(reset_n), .async_i(DCLK),
    .rise_o(dclk_rise), .fall_o(dclk_fall)
  );

  // DXMIT_BAR idles high, so its history resets high to avoid a false fall.
  ddc112_sync_edge #(.RESET_VAL(1'b1)) u_sync_xmit (
    .clk_i(sys_clk), .rst_ni(reset_n), .async_i(DXMIT_BAR),
    .rise_o(xmit_rise), .fall_o(xmit_fall)
  );

  assign conv_edge = conv_rise | conv_fall;

  emu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [FW-1:0]     sr_q, sr_d;
  logic              dvalid_bar_q, dvalid_bar_d;
  logic              dout_q, dout_d;
  logic              overrun_q, overrun_d;
  logic [FW-1:0]     latch_frame;
  logic              latch_en;

`ifdef DDC112_EMU_RAMP_EN
  logic [DATA_W-1:0] ramp_q;
  assign latch_frame = {ramp_q, ~ramp_q};
`else
  assign latch_frame = {data_a, data_b};
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    sr_d         = sr_q;
    dvalid_bar_d = dvalid_bar_q;
    dout_d       = dout_q;
    overrun_d    = overrun_q;
    latch_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        dvalid_bar_d = 1'b1;
        dout_d       = 1'b0;
        if (conv_edge) begin
          cnt_d   = CNT_W'(CONV_CYCLES - 1);
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (conv_edge) begin
          cnt_d = CNT_W'(CONV_CYCLES - 1);
        end else if (cnt_q == '0) begin
          sr_d         = latch_frame;
          latch_en     = 1'b1;
          dvalid_bar_d = 1'b0;
          state_d      = VALID;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      VALID: begin
        if (conv_edge) begin
          overrun_d = 1'b1;
          cnt_d     = CNT_W'(CONV_CYCLES - 1);
          state_d   = CONVERT;
        end else if (xmit_fall) begin
          dvalid_bar_d = 1'b1;
          dout_d       = sr_q[FW-1];
          bit_d        = '0;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        if (xmit_rise) begin
          dout_d  = 1'b0;
          state_d = IDLE;
        end else if (dclk_rise && bit_q != BIT_W'(FW)) begin
          sr_d   = {sr_q[FW-2:0], 1'b0};
          bit_d  = bit_q + 1'b1;
          dout_d = (bit_q == BIT_W'(FW - 1)) ? 1'b0 : sr_q[FW-2];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sr_q         <= '0;
      dvalid_bar_q <= 1'b1;
      dout_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sr_q         <= sr_d;
      dvalid_bar_q <= dvalid_bar_d;
      dout_q       <= dout_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef DDC112_EMU_RAMP_EN
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)      ramp_q <= '0;
    else if (latch_en) ramp_q <= ramp_q + 1'b1;
  end
`endif

  assign DVALID_BAR = dvalid_bar_q;
  assign DOUT       = dout_q;
  assign overrun    = overrun_q;
  assign emu_state  = state_q;

endmodule
